// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge
// ---------------------------------------------------------------------------
// Turns one SRAM-like master port (req / addr_ok / data_ok split handshake)
// into a single-ID AXI master with exactly one transaction in flight.
// Constant AXI fields (id, len, burst, lock, cache, prot, wid, wlast) are
// tied off by the instantiating top and do not appear here.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   sram_req/wr/size/wstrb/addr/wdata   SRAM-like request (held until addr_ok)
//   sram_addr_ok      request accepted this cycle (combinational, = IDLE)
//   sram_data_ok      registered one-cycle pulse: read data valid / write done
//   sram_rdata        read data, valid while sram_data_ok is high
//   ar*, r*           AXI read address / read data channels
//   aw*, w*, b*       AXI write address / write data / write response channels
//   dbg_state_o       current FSM state (IDLE=0, RD_AR=1, RD_R=2, WR_REQ=3, WR_B=4)
//
// Handshake rule on every AXI channel: a transfer happens on a rising edge
// where valid and ready are both high; once a valid is raised, it and its
// payload stay constant until that transfer happens.
// ---------------------------------------------------------------------------
module sram_axi_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    // SRAM-like slave side
    input  logic                sram_req,
    input  logic                sram_wr,
    input  logic [1:0]          sram_size,
    input  logic [DATA_W/8-1:0] sram_wstrb,
    input  logic [ADDR_W-1:0]   sram_addr,
    input  logic [DATA_W-1:0]   sram_wdata,
    output logic                sram_addr_ok,
    output logic                sram_data_ok,
    output logic [DATA_W-1:0]   sram_rdata,
    // AXI read address
    output logic [ADDR_W-1:0]   araddr,
    output logic [2:0]          arsize,
    output logic                arvalid,
    input  logic                arready,
    // AXI read data
    input  logic [DATA_W-1:0]   rdata,
    input  logic                rvalid,
    output logic                rready,
    // AXI write address
    output logic [ADDR_W-1:0]   awaddr,
    output logic [2:0]          awsize,
    output logic                awvalid,
    input  logic                awready,
    // AXI write data
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    // AXI write response
    input  logic                bvalid,
    output logic                bready,
    // debug
    output logic [2:0]          dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_AR  = 3'd1,
        RD_R   = 3'd2,
        WR_REQ = 3'd3,
        WR_B   = 3'd4
    } state_e;

    state_e state_q, state_d;

    // Request latch
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic [DATA_W/8-1:0] strb_q, strb_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    // Write-side handshake progress inside WR_REQ
    logic aw_done_q, aw_done_d;
    logic w_done_q, w_done_d;

    // Registered outputs
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              data_ok_q, data_ok_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic accept;
    logic ar_fire, r_fire, aw_fire, w_fire, b_fire;
    logic aw_done_nx, w_done_nx;

    assign sram_addr_ok = (state_q == IDLE);
    assign accept       = sram_req & sram_addr_ok;

    assign ar_fire = arvalid_q & arready;
    assign r_fire  = rready_q & rvalid;
    assign aw_fire = awvalid_q & awready;
    assign w_fire  = wvalid_q & wready;
    assign b_fire  = bready_q & bvalid;

    // Progress including a handshake completing this very cycle, so AW and W
    // finishing together (or the second one finishing) leaves WR_REQ at once.
    assign aw_done_nx = aw_done_q | aw_fire;
    assign w_done_nx  = w_done_q | w_fire;

    // ------------------------------------------------------------------
    // State register (plus all datapath / output registers)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            strb_q    <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            strb_q    <= strb_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = sram_wr ? WR_REQ : RD_AR;
                end
            end
            RD_AR: begin
                if (ar_fire) begin
                    state_d = RD_R;
                end
            end
            RD_R: begin
                if (r_fire) begin
                    state_d = IDLE;
                end
            end
            WR_REQ: begin
                aw_done_d = aw_done_nx;
                w_done_d  = w_done_nx;
                if (aw_done_nx && w_done_nx) begin
                    state_d   = WR_B;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            WR_B: begin
                if (b_fire) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: valids/readies are registered copies decoded from the
    // next state, so they change exactly on the state transition edge.
    // ------------------------------------------------------------------
    always_comb begin
        addr_d  = addr_q;
        size_d  = size_q;
        strb_d  = strb_q;
        wdata_d = wdata_q;
        if (accept) begin
            addr_d  = sram_addr;
            // Size 3 is not a legal SRAM size; clamp it to a word access.
            size_d  = (sram_size == 2'd3) ? 2'd2 : sram_size;
            strb_d  = sram_wstrb;
            wdata_d = sram_wdata;
        end

        arvalid_d = (state_d == RD_AR);
        rready_d  = (state_d == RD_R);
        awvalid_d = (state_d == WR_REQ) && !aw_done_d;
        wvalid_d  = (state_d == WR_REQ) && !w_done_d;
        bready_d  = (state_d == WR_B);

        data_ok_d = r_fire | b_fire;
        rdata_d   = r_fire ? rdata : rdata_q;
    end

    assign sram_data_ok = data_ok_q;
    assign sram_rdata   = rdata_q;

    assign araddr  = addr_q;
    assign arsize  = {1'b0, size_q};
    assign arvalid = arvalid_q;
    assign rready  = rready_q;

    assign awaddr  = addr_q;
    assign awsize  = {1'b0, size_q};
    assign awvalid = awvalid_q;
    assign wdata   = wdata_q;
    assign wstrb   = strb_q;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Bench for sram_axi_bridge: random AXI slave, request driver, a transaction
// level model of the bridge checked on every cycle, and directed scenarios
// with hand-computed cycle counts and values.
module tb_sram_axi_bridge;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------
    logic        sram_req = 1'b0;
    logic        sram_wr = 1'b0;
    logic [1:0]  sram_size = 2'd0;
    logic [3:0]  sram_wstrb = 4'd0;
    logic [31:0] sram_addr = 32'd0;
    logic [31:0] sram_wdata = 32'd0;
    logic        sram_addr_ok, sram_data_ok;
    logic [31:0] sram_rdata;
    logic [31:0] araddr, awaddr, wdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, rready, awvalid, wvalid, bready;
    logic [3:0]  wstrb;
    logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic [2:0]  dbg_state;

    sram_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size),
        .sram_wstrb(sram_wstrb), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready),
        .dbg_state_o(dbg_state)
    );

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    // ------------------------------------------------------------------
    // Random AXI slave (inputs change 1ns after the rising edge)
    // ------------------------------------------------------------------
    int ar_p = 100, r_p = 100, aw_p = 100, w_p = 100, b_p = 100;
    bit use_fixed = 1'b0;
    logic [31:0] fixed_rdata = 32'd0;
    bit rd_owed = 1'b0, aw_got = 1'b0, w_got = 1'b0;

    function automatic bit roll(input int p);
        return int'($urandom_range(99, 0)) < p;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                rd_owed = 1'b0;
                aw_got  = 1'b0;
                w_got   = 1'b0;
            end else begin
                if (arvalid && arready) rd_owed = 1'b1;
                if (rvalid && rready)   rd_owed = 1'b0;
                if (awvalid && awready) aw_got = 1'b1;
                if (wvalid && wready)   w_got = 1'b1;
                if (bvalid && bready) begin
                    aw_got = 1'b0;
                    w_got  = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            arready = roll(ar_p);
            awready = roll(aw_p);
            wready  = roll(w_p);
            if (rd_owed) begin
                if (!rvalid && roll(r_p)) begin
                    rvalid = 1'b1;
                    rdata  = use_fixed ? fixed_rdata : $urandom;
                end
            end else begin
                rvalid = 1'b0;
                rdata  = $urandom;
            end
            if (aw_got && w_got) begin
                if (!bvalid && roll(b_p)) bvalid = 1'b1;
            end else begin
                bvalid = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transaction-level model + per-cycle compare
    // A request is either absent or in flight; a read first owes one AR
    // transfer then one R transfer, a write owes AW and W (any order) then
    // one B transfer. The completion is reported on data_ok the cycle after
    // the final transfer.
    // ------------------------------------------------------------------
    logic [31:0] exp_q[$];
    bit          kind_q[$];
    bit          pending = 1'b0;
    bit          ar_seen = 1'b0, aw_seen = 1'b0, w_seen = 1'b0;
    bit          cur_wr = 1'b0;
    logic [31:0] cur_addr = 32'd0, cur_wdata = 32'd0;
    logic [1:0]  cur_size = 2'd0;
    logic [3:0]  cur_strb = 4'd0;
    bit          was_idle, k_rd;
    logic [31:0] e_val;
    int          ok_total = 0;
    int          last_ok_cyc = -1;

    always @(negedge clk) begin
        if (reset) begin
            pending = 1'b0;
            ar_seen = 1'b0;
            aw_seen = 1'b0;
            w_seen  = 1'b0;
            exp_q.delete();
            kind_q.delete();
        end else begin
            was_idle = !pending;
            chk1("addr_ok", sram_addr_ok, was_idle);
            chk1("data_ok", sram_data_ok, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                e_val = exp_q.pop_front();
                k_rd  = kind_q.pop_front();
                if (sram_data_ok && k_rd) chk("sram_rdata", sram_rdata, e_val);
            end
            if (sram_data_ok) begin
                ok_total++;
                last_ok_cyc = cyc;
            end

            chk1("arvalid", arvalid, pending && !cur_wr && !ar_seen);
            chk1("rready",  rready,  pending && !cur_wr && ar_seen);
            chk1("awvalid", awvalid, pending && cur_wr && !aw_seen);
            chk1("wvalid",  wvalid,  pending && cur_wr && !w_seen);
            chk1("bready",  bready,  pending && cur_wr && aw_seen && w_seen);
            if (arvalid) begin
                chk("araddr", araddr, cur_addr);
                chk("arsize", {29'd0, arsize}, {29'd0, 1'b0, cur_size});
            end
            if (awvalid) begin
                chk("awaddr", awaddr, cur_addr);
                chk("awsize", {29'd0, awsize}, {29'd0, 1'b0, cur_size});
            end
            if (wvalid) begin
                chk("wdata", wdata, cur_wdata);
                chk("wstrb", {28'd0, wstrb}, {28'd0, cur_strb});
            end

            // advance the model over the coming edge
            if (pending && !cur_wr) begin
                if (!ar_seen) begin
                    if (arready) ar_seen = 1'b1;
                end else if (rvalid) begin
                    exp_q.push_back(rdata);
                    kind_q.push_back(1'b1);
                    pending = 1'b0;
                end
            end else if (pending && cur_wr) begin
                if (aw_seen && w_seen) begin
                    if (bvalid) begin
                        exp_q.push_back(32'd0);
                        kind_q.push_back(1'b0);
                        pending = 1'b0;
                    end
                end else begin
                    if (awready) aw_seen = 1'b1;
                    if (wready)  w_seen  = 1'b1;
                end
            end
            if (was_idle && sram_req) begin
                pending   = 1'b1;
                ar_seen   = 1'b0;
                aw_seen   = 1'b0;
                w_seen    = 1'b0;
                cur_wr    = sram_wr;
                cur_addr  = sram_addr;
                cur_size  = (sram_size == 2'd3) ? 2'd2 : sram_size;
                cur_strb  = sram_wstrb;
                cur_wdata = sram_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    // Raise a request, hold it until accepted, then drop req and scramble
    // the other request inputs (the busy bridge must ignore them).
    // Returns 1ns after the edge following acceptance.
    task automatic issue(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                         input logic [3:0] strb, input logic [31:0] wd, output int acc);
        @(posedge clk);
        #1;
        sram_req   = 1'b1;
        sram_wr    = wr;
        sram_addr  = addr;
        sram_size  = size;
        sram_wstrb = strb;
        sram_wdata = wd;
        acc = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (sram_addr_ok) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=none expected=addr_ok cycle=%0d", cyc);
        end
        @(posedge clk);
        #1;
        sram_req   = 1'b0;
        sram_wr    = 1'($urandom);
        sram_addr  = $urandom;
        sram_size  = 2'($urandom);
        sram_wstrb = 4'($urandom);
        sram_wdata = $urandom;
    endtask

    // Wait (bounded) for the next data_ok, counting valid/ready cycles seen.
    task automatic wait_done(output int done, output int n_ar, output int n_aw,
                             output int n_w, output int n_b, output logic [31:0] rd,
                             output logic [31:0] ar_a, output logic [2:0] ar_s);
        done = -1; n_ar = 0; n_aw = 0; n_w = 0; n_b = 0;
        rd = 32'd0; ar_a = 32'd0; ar_s = 3'd0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (arvalid) begin
                if (n_ar == 0) begin
                    ar_a = araddr;
                    ar_s = arsize;
                end
                n_ar++;
            end
            if (awvalid) n_aw++;
            if (wvalid)  n_w++;
            if (bready)  n_b++;
            if (sram_data_ok) begin
                done = cyc;
                rd   = sram_rdata;
                break;
            end
        end
        if (done < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=none expected=data_ok cycle=%0d", cyc);
        end
        #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int acc, acc2, done, n_ar, n_aw, n_w, n_b, ok0, pre_aw, pre_w;
    logic [31:0] rd, ar_a;
    logic [2:0]  ar_s;

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        // reset state
        chk1("rst_arvalid", arvalid, 1'b0);
        chk1("rst_awvalid", awvalid, 1'b0);
        chk1("rst_wvalid",  wvalid,  1'b0);
        chk1("rst_rready",  rready,  1'b0);
        chk1("rst_bready",  bready,  1'b0);
        chk1("rst_data_ok", sram_data_ok, 1'b0);
        chk("rst_rdata", sram_rdata, 32'd0);
        chk("rst_state", {29'd0, dbg_state}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // zero-wait read
        use_fixed = 1'b1;
        fixed_rdata = 32'hDEADBEEF;
        issue(1'b0, 32'h1c000000, 2'd2, 4'hf, 32'd0, acc);
        wait_done(done, n_ar, n_aw, n_w, n_b, rd, ar_a, ar_s);
        use_fixed = 1'b0;
        chk("rd0_latency", done - acc, 3);
        chk("rd0_rdata", rd, 32'hDEADBEEF);
        chk("rd0_ar_cycles", n_ar, 1);
        chk("rd0_araddr", ar_a, 32'h1c000000);
        chk("rd0_arsize", {29'd0, ar_s}, 32'd2);

        // read with AR held off for 5 cycles
        ar_p = 0;
        issue(1'b0, 32'h20000040, 2'd0, 4'h0, 32'd0, acc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("bp_arvalid", arvalid, 1'b1);
            chk("bp_araddr", araddr, 32'h20000040);
            chk1("bp_addr_ok", sram_addr_ok, 1'b0);
            chk1("bp_data_ok", sram_data_ok, 1'b0);
        end
        ar_p = 100;
        wait_done(done, n_ar, n_aw, n_w, n_b, rd, ar_a, ar_s);
        chk("bp_latency", done - acc, 8);

        // write with W accepted at cycle 1 and AW at cycle 4
        aw_p = 0;
        issue(1'b1, 32'h00000100, 2'd1, 4'h3, 32'h12345678, acc);
        pre_aw = 0;
        pre_w  = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (awvalid) pre_aw++;
            if (wvalid)  pre_w++;
        end
        aw_p = 100;
        wait_done(done, n_ar, n_aw, n_w, n_b, rd, ar_a, ar_s);
        chk("wr_aw_cycles", pre_aw + n_aw, 4);
        chk("wr_w_cycles", pre_w + n_w, 1);
        chk("wr_b_cycles", n_b, 1);
        chk("wr_latency", done - acc, 6);

        // back-to-back: write, then a read held on req while the write runs
        ok0 = ok_total;
        issue(1'b1, 32'h00000200, 2'd2, 4'hf, 32'hCAFEF00D, acc);
        issue(1'b0, 32'h00000300, 2'd2, 4'h0, 32'd0, acc2);
        chk("b2b_accept_cycle", acc2 - acc, 3);
        chk("b2b_accept_on_ok", acc2, last_ok_cyc);
        wait_done(done, n_ar, n_aw, n_w, n_b, rd, ar_a, ar_s);
        chk("b2b_rd_latency", done - acc2, 3);
        chk("b2b_ok_count", ok_total - ok0, 2);

        // reset while waiting in the read-data phase
        r_p = 0;
        issue(1'b0, 32'h1c000010, 2'd2, 4'h0, 32'd0, acc);
        @(negedge clk);
        @(negedge clk);
        chk1("mid_rready", rready, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk1("mid_rst_arvalid", arvalid, 1'b0);
        chk1("mid_rst_rready", rready, 1'b0);
        chk1("mid_rst_data_ok", sram_data_ok, 1'b0);
        chk("mid_rst_state", {29'd0, dbg_state}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        r_p = 100;
        @(negedge clk);
        chk1("mid_post_addr_ok", sram_addr_ok, 1'b1);
        chk1("mid_post_data_ok", sram_data_ok, 1'b0);

        // random traffic against a random slave
        for (int t = 0; t < 200; t++) begin
            if (t % 8 == 0) begin
                ar_p = int'($urandom_range(100, 20));
                r_p  = int'($urandom_range(100, 20));
                aw_p = int'($urandom_range(100, 20));
                w_p  = int'($urandom_range(100, 20));
                b_p  = int'($urandom_range(100, 20));
            end
            issue(1'($urandom), $urandom, 2'($urandom), 4'($urandom), $urandom, acc);
            if ($urandom_range(3, 0) == 0) repeat ($urandom_range(4, 0)) @(posedge clk);
        end

        // drain the last transaction
        done = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (sram_addr_ok && exp_q.size() == 0) begin
                done = cyc;
                break;
            end
        end
        if (done < 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=busy expected=idle cycle=%0d", cyc);
        end
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
